// File: rtl/mmss_timer_ctrl.sv
// mmss_timer_ctrl
//   Sequencer for an external MM:SS chain of BCD digit counters
//   (d0 = seconds units, d1 = seconds tens, d2 = minutes units,
//   d3 = minutes tens). It divides clk down to the count rate and runs
//   the start/pause/expire state machine for the stopwatch (count-up)
//   and timer (count-down) modes. It also produces the per-digit
//   enable, direction and clear strobes, with carry/borrow chaining
//   computed from the current digit values.
//
// Ports
//   clk         clock
//   rst         synchronous, active-high reset (shared with the digit counters)
//   start_stop  one-cycle pulse: start from IDLE, pause, resume, or leave DONE
//   clear       one-cycle pulse: zero all digits and return to IDLE
//   mode_down   1 = countdown, 0 = count-up; looked at only when starting from IDLE
//   inc_sec     one-cycle pulse: +1 second while setting (IDLE/PAUSE)
//   inc_min     one-cycle pulse: +1 minute while setting (IDLE/PAUSE)
//   digits      {d3,d2,d1,d0} current BCD digit values
//   dig_en      registered per-digit count enables
//   dig_dir     registered count direction, 1 = up, 0 = down
//   dig_clr     registered one-cycle clear strobe to all digits
//   running     high in RUN_UP / RUN_DOWN
//   expired     high in DONE
module mmss_timer_ctrl #(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        mode_down,
  input  logic        inc_sec,
  input  logic        inc_min,
  input  logic [15:0] digits,
  output logic [3:0]  dig_en,
  output logic        dig_dir,
  output logic        dig_clr,
  output logic        running,
  output logic        expired
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {IDLE, RUN_UP, RUN_DOWN, PAUSE, DONE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic          tick, tick_nxt;
  logic          dir_down, dir_down_nxt;   // direction of the run a PAUSE returns to
  logic [3:0]    dig_en_nxt;
  logic          dig_dir_nxt;
  logic          dig_clr_nxt;
  logic          set_fire;

  logic at_zero, at_max, wrap, is_run;

  assign at_zero = (digits == 16'h0000);
  assign at_max  = (digits == 16'h5959);
  assign wrap    = (presc == PRESC_LAST);
  assign is_run  = (state == RUN_UP) || (state == RUN_DOWN);

  assign running = is_run;
  assign expired = (state == DONE);

  // Carry/borrow chain: a digit steps when the trigger is present and every
  // lower digit sits at its terminal value (9,5,9 going up; 0 going down).
  function automatic logic [3:0] chain(input logic t, input logic up, input logic [11:0] d);
    logic [3:0] en;
    en[0] = t;
    en[1] = en[0] & (d[3:0]  == (up ? 4'd9 : 4'd0));
    en[2] = en[1] & (d[7:4]  == (up ? 4'd5 : 4'd0));
    en[3] = en[2] & (d[11:8] == (up ? 4'd9 : 4'd0));
    return en;
  endfunction

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nxt    = state;
    presc_nxt    = presc;
    tick_nxt     = tick;
    dir_down_nxt = dir_down;
    dig_en_nxt   = '0;
    dig_clr_nxt  = 1'b0;
    set_fire     = 1'b0;

    if (clear) begin
      state_nxt   = IDLE;
      presc_nxt   = '0;
      tick_nxt    = 1'b0;
      dig_clr_nxt = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          presc_nxt = '0;
          tick_nxt  = 1'b0;
          if (start_stop) begin
            if (!mode_down) begin
              state_nxt    = RUN_UP;
              dir_down_nxt = 1'b0;
            end else if (!at_zero) begin
              state_nxt    = RUN_DOWN;
              dir_down_nxt = 1'b1;
            end
          end else begin
            // Seconds and minutes are independent chains: no carry between them.
            dig_en_nxt = {inc_min & (digits[11:8] == 4'd9), inc_min,
                          inc_sec & (digits[3:0] == 4'd9), inc_sec};
            set_fire   = inc_sec | inc_min;
          end
        end

        RUN_UP, RUN_DOWN: begin
          presc_nxt = wrap ? '0 : presc + 1'b1;
          if (start_stop) begin
            state_nxt = PAUSE;
            // A tick landing on the pause edge stays pending until resume.
            tick_nxt  = wrap | tick;
          end else if (dig_en == 4'b0 && (state == RUN_UP ? at_max : at_zero)) begin
            state_nxt = DONE;
            presc_nxt = '0;
            tick_nxt  = 1'b0;
          end else begin
            tick_nxt   = wrap;
            dig_en_nxt = chain(tick, state == RUN_UP, digits[11:0]);
          end
        end

        PAUSE: begin
          if (start_stop) begin
            state_nxt = dir_down ? RUN_DOWN : RUN_UP;
          end else begin
            dig_en_nxt = {inc_min & (digits[11:8] == 4'd9), inc_min,
                          inc_sec & (digits[3:0] == 4'd9), inc_sec};
            set_fire   = inc_sec | inc_min;
          end
        end

        DONE: begin
          presc_nxt = '0;
          tick_nxt  = 1'b0;
          if (start_stop) state_nxt = IDLE;
        end

        default: state_nxt = IDLE;
      endcase
    end

    // Setting always counts up, even while paused out of a countdown; otherwise
    // the direction follows the state being entered so it is valid before the
    // first enable of a run.
    dig_dir_nxt = set_fire ||
                  !((state_nxt == RUN_DOWN) || (state_nxt == PAUSE && dir_down_nxt));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      presc    <= '0;
      tick     <= 1'b0;
      dir_down <= 1'b0;
      dig_en   <= '0;
      dig_dir  <= 1'b1;
      dig_clr  <= 1'b0;
    end else begin
      state    <= state_nxt;
      presc    <= presc_nxt;
      tick     <= tick_nxt;
      dir_down <= dir_down_nxt;
      dig_en   <= dig_en_nxt;
      dig_dir  <= dig_dir_nxt;
      dig_clr  <= dig_clr_nxt;
    end
  end

endmodule

// File: tb/tb_mmss_timer_ctrl.sv
// tb_mmss_timer_ctrl
//   Self-checking bench for mmss_timer_ctrl with CLK_HZ=10, TICK_HZ=1.
//   The bench contains its own set of BCD digit counters driven by the
//   DUT strobes. Expected values come from the elapsed time kept as plain
//   seconds: the enables expected at a tick are the digits that differ
//   between the MM:SS forms of the old and the new time.
module tb_mmss_timer_ctrl;

  localparam int CLK_HZ   = 10;
  localparam int TICK_HZ  = 1;
  localparam int PRESCALE = CLK_HZ / TICK_HZ;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        mode_down = 1'b0;
  logic        inc_sec = 1'b0;
  logic        inc_min = 1'b0;
  logic [15:0] digits;
  logic [3:0]  dig_en;
  logic        dig_dir;
  logic        dig_clr;
  logic        running;
  logic        expired;

  logic        pre_req = 1'b0;
  logic [15:0] pre_val = 16'h0000;

  int n_pass  = 0;
  int n_total = 0;
  int ref_secs = 0;     // expected time in seconds (mm*60+ss)
  bit ref_down = 1'b0;  // direction of the current run

  mmss_timer_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_stop(start_stop),
    .clear     (clear),
    .mode_down (mode_down),
    .inc_sec   (inc_sec),
    .inc_min   (inc_min),
    .digits    (digits),
    .dig_en    (dig_en),
    .dig_dir   (dig_dir),
    .dig_clr   (dig_clr),
    .running   (running),
    .expired   (expired)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [3:0] changed(input logic [15:0] a, input logic [15:0] b);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (a[4*i +: 4] != b[4*i +: 4]);
    return m;
  endfunction

  function automatic logic [3:0] bump(input logic [3:0] d, input int i, input logic up);
    logic [3:0] lim;
    lim = (i % 2 == 0) ? 4'd9 : 4'd5;
    if (up) return (d == lim) ? 4'd0 : d + 4'd1;
    return (d == 4'd0) ? lim : d - 4'd1;
  endfunction

  // External digit counters, with a preload port used only by the bench.
  always @(posedge clk) begin
    if (rst) digits <= 16'h0000;
    else if (pre_req) digits <= pre_val;
    else if (dig_clr) digits <= 16'h0000;
    else
      for (int i = 0; i < 4; i++)
        if (dig_en[i]) digits[4*i +: 4] <= bump(digits[4*i +: 4], i, dig_dir);
  end

  task automatic pulse_ss();
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
  endtask

  task automatic go_idle();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    ref_secs = 0;
  endtask

  task automatic preload(input int s);
    pre_val  = to_bcd(s);
    pre_req  = 1'b1;
    @(negedge clk);
    pre_req  = 1'b0;
    ref_secs = s;
  endtask

  // Waits first_gap cycles for the next enable, then PRESCALE per further tick.
  task automatic run_ticks(input int nsec, input int first_gap);
    int gap, nxt;
    bit stray;
    gap = first_gap;
    for (int n = 0; n < nsec; n++) begin
      nxt   = ref_down ? ref_secs - 1 : ref_secs + 1;
      stray = 1'b0;
      for (int c = 1; c < gap; c++) begin
        @(negedge clk);
        if (dig_en !== 4'b0000) stray = 1'b1;
      end
      @(negedge clk);
      n_total++;
      if (stray) $display("FAIL early_en: got enable before tick at %0t, want none", $time);
      else n_pass++;
      n_total++;
      if (dig_en !== changed(to_bcd(ref_secs), to_bcd(nxt)))
        $display("FAIL tick_en: got %b want %b at %0t", dig_en,
                 changed(to_bcd(ref_secs), to_bcd(nxt)), $time);
      else n_pass++;
      n_total++;
      if (digits !== to_bcd(ref_secs))
        $display("FAIL tick_digits: got %h want %h at %0t", digits, to_bcd(ref_secs), $time);
      else n_pass++;
      ref_secs = nxt;
      gap = PRESCALE;
    end
  endtask

  // Called at the cycle of the last enable of a run that reaches its end value.
  task automatic expect_done();
    bit stray;
    @(negedge clk);
    n_total++;
    if ({digits, running, expired} !== {to_bcd(ref_secs), 2'b10})
      $display("FAIL end_value: got %h run=%b exp=%b want %h run=1 exp=0",
               digits, running, expired, to_bcd(ref_secs));
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({running, expired} !== 2'b01)
      $display("FAIL done_entry: got run=%b exp=%b want run=0 exp=1", running, expired);
    else n_pass++;
    stray = 1'b0;
    for (int c = 0; c < 3 * PRESCALE; c++) begin
      @(negedge clk);
      if (dig_en !== 4'b0000 || expired !== 1'b1) stray = 1'b1;
    end
    n_total++;
    if (stray) $display("FAIL done_hold: got enable or expired drop in DONE, want quiet");
    else n_pass++;
  endtask

  task automatic pulse_inc(input bit s, input bit m);
    int mm, ss, nxt;
    mm = ref_secs / 60;
    ss = ref_secs % 60;
    if (s) ss = (ss + 1) % 60;
    if (m) mm = (mm + 1) % 60;
    nxt = mm * 60 + ss;
    inc_sec = s;
    inc_min = m;
    @(negedge clk);
    inc_sec = 1'b0;
    inc_min = 1'b0;
    n_total++;
    if ({dig_en, dig_dir} !== {changed(to_bcd(ref_secs), to_bcd(nxt)), 1'b1})
      $display("FAIL set_en: got en=%b dir=%b want en=%b dir=1", dig_en, dig_dir,
               changed(to_bcd(ref_secs), to_bcd(nxt)));
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (digits !== to_bcd(nxt))
      $display("FAIL set_digits: got %h want %h", digits, to_bcd(nxt));
    else n_pass++;
    ref_secs = nxt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({dig_en, dig_dir, dig_clr, running, expired} !== 8'b0000_1000)
      $display("FAIL reset_outputs: got %b want 00001000",
               {dig_en, dig_dir, dig_clr, running, expired});
    else n_pass++;
    rst = 1'b0;
    repeat (PRESCALE + 2) @(negedge clk);
    n_total++;
    if ({dig_en, dig_dir, dig_clr, running, expired} !== 8'b0000_1000)
      $display("FAIL idle_outputs: got %b want 00001000",
               {dig_en, dig_dir, dig_clr, running, expired});
    else n_pass++;
  endtask

  task automatic test_count_up();
    go_idle();
    mode_down = 1'b0;
    ref_down  = 1'b0;
    pulse_ss();
    n_total++;
    if ({running, dig_dir, expired} !== 3'b110)
      $display("FAIL up_start: got run=%b dir=%b exp=%b want 1 1 0", running, dig_dir, expired);
    else n_pass++;
    // First enable lands PRESCALE+1 cycles after the start edge.
    run_ticks(12, PRESCALE + 1);
    for (int r = 0; r < 3; r++) begin
      go_idle();
      preload($urandom_range(0, 3500));
      pulse_ss();
      run_ticks($urandom_range(2, 12), PRESCALE + 1);
    end
  endtask

  task automatic test_carry_saturate();
    go_idle();
    preload(9 * 60 + 59);
    ref_down = 1'b0;
    pulse_ss();
    run_ticks(1, PRESCALE + 1);
    go_idle();
    preload(59 * 60 + 57);
    pulse_ss();
    run_ticks(2, PRESCALE + 1);
    expect_done();
    pulse_ss();
    n_total++;
    if ({running, expired} !== 2'b00)
      $display("FAIL done_exit: got run=%b exp=%b want 0 0", running, expired);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (digits !== 16'h5959) $display("FAIL done_keep_digits: got %h want 5959", digits);
    else n_pass++;
  endtask

  task automatic test_countdown();
    go_idle();
    pulse_inc(1'b0, 1'b1);
    mode_down = 1'b1;
    ref_down  = 1'b1;
    pulse_ss();
    n_total++;
    if ({running, dig_dir} !== 2'b10)
      $display("FAIL down_start: got run=%b dir=%b want run=1 dir=0", running, dig_dir);
    else n_pass++;
    run_ticks(60, PRESCALE + 1);
    expect_done();
    pulse_ss();
    n_total++;
    if ({running, expired, digits} !== {2'b00, 16'h0000})
      $display("FAIL down_exit: got run=%b exp=%b dig=%h want 0 0 0000", running, expired, digits);
    else n_pass++;
    mode_down = 1'b0;
    ref_down  = 1'b0;
  endtask

  task automatic test_set_mode();
    int r;
    go_idle();
    for (int k = 0; k < 8; k++) begin
      r = $urandom_range(1, 3);
      pulse_inc(r[0], r[1]);
    end
    preload(59 * 60 + 59);
    pulse_inc(1'b1, 1'b1);
    // Increments are ignored while running: pulse one at a non-tick cycle.
    mode_down = 1'b0;
    ref_down  = 1'b0;
    pulse_ss();
    inc_sec = 1'b1;
    inc_min = 1'b1;
    @(negedge clk);
    inc_sec = 1'b0;
    inc_min = 1'b0;
    @(negedge clk);
    n_total++;
    if (dig_en !== 4'b0000) $display("FAIL run_ignores_inc: got %b want 0000", dig_en);
    else n_pass++;
    run_ticks(1, PRESCALE - 1);
  endtask

  task automatic test_pause();
    int p, hold;
    bit dir, stray;
    for (int it = 0; it < 3; it++) begin
      go_idle();
      preload($urandom_range(200, 3000));
      dir       = (it == 0) ? 1'b0 : (it == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      mode_down = dir;
      ref_down  = dir;
      pulse_ss();
      p    = (it == 0) ? 3 : $urandom_range(1, PRESCALE - 1);
      hold = (it == 0) ? 50 : $urandom_range(5, 40);
      repeat (p - 1) @(negedge clk);
      pulse_ss();
      n_total++;
      if ({running, dig_dir} !== {1'b0, ~dir})
        $display("FAIL pause_entry: got run=%b dir=%b want run=0 dir=%b", running, dig_dir, ~dir);
      else n_pass++;
      stray = 1'b0;
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        if (dig_en !== 4'b0000 || running !== 1'b0) stray = 1'b1;
      end
      n_total++;
      if (stray) $display("FAIL pause_hold: got enable or running in PAUSE, want quiet");
      else n_pass++;
      if (dir) begin
        pulse_inc(1'b1, 1'b0);
        n_total++;
        if (dig_dir !== 1'b0) $display("FAIL pause_dir_restore: got %b want 0", dig_dir);
        else n_pass++;
      end
      mode_down = ~dir;
      pulse_ss();
      n_total++;
      if ({running, dig_dir} !== {1'b1, ~dir})
        $display("FAIL resume: got run=%b dir=%b want run=1 dir=%b", running, dig_dir, ~dir);
      else n_pass++;
      // p prescale counts were spent before the pause.
      run_ticks(3, PRESCALE - p + 1);
    end
    mode_down = 1'b0;
    ref_down  = 1'b0;
  endtask

  task automatic test_zero_down();
    bit stray;
    go_idle();
    mode_down = 1'b1;
    pulse_ss();
    n_total++;
    if ({running, dig_dir, expired} !== 3'b010)
      $display("FAIL zero_down_start: got run=%b dir=%b exp=%b want 0 1 0", running, dig_dir, expired);
    else n_pass++;
    stray = 1'b0;
    for (int c = 0; c < 2 * PRESCALE; c++) begin
      @(negedge clk);
      if (dig_en !== 4'b0000 || running !== 1'b0) stray = 1'b1;
    end
    n_total++;
    if (stray) $display("FAIL zero_down_idle: got activity, want stay IDLE");
    else n_pass++;
    mode_down = 1'b0;
  endtask

  task automatic test_clear_priority();
    go_idle();
    ref_down = 1'b0;
    pulse_ss();
    run_ticks(1, PRESCALE + 1);
    repeat (3) @(negedge clk);
    clear      = 1'b1;
    start_stop = 1'b1;
    @(negedge clk);
    clear      = 1'b0;
    start_stop = 1'b0;
    n_total++;
    if ({dig_clr, dig_en, running, expired} !== 7'b1_0000_00)
      $display("FAIL clear_strobe: got clr=%b en=%b run=%b exp=%b want 1 0000 0 0",
               dig_clr, dig_en, running, expired);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({dig_clr, digits} !== {1'b0, 16'h0000})
      $display("FAIL clear_once: got clr=%b dig=%h want 0 0000", dig_clr, digits);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (running !== 1'b0) $display("FAIL clear_idle: got run=%b want 0", running);
    else n_pass++;
    ref_secs = 0;
  endtask

  task automatic test_reset_mid_run();
    go_idle();
    preload($urandom_range(0, 3000));
    ref_down = 1'b0;
    pulse_ss();
    run_ticks(1, PRESCALE + 1);
    repeat ($urandom_range(1, 7)) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if ({dig_en, dig_dir, dig_clr, running, expired} !== 8'b0000_1000)
      $display("FAIL midrun_reset: got %b want 00001000",
               {dig_en, dig_dir, dig_clr, running, expired});
    else n_pass++;
    rst = 1'b0;
    ref_secs = 0;
    @(negedge clk);
    pulse_ss();
    run_ticks(2, PRESCALE + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by %0t, want bench completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_count_up();
    test_carry_saturate();
    test_countdown();
    test_set_mode();
    test_pause();
    test_zero_down();
    test_clear_priority();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
